// File: rtl/vita49_pkg.sv
// VITA-49 shared definitions: header field layout, codes and FSM encodings.
// The unpack side imports the same encodings.
package vita49_pkg;

  localparam logic [3:0] PKT_TYPE_IF_SID = 4'b0001;
  localparam logic [1:0] TSI_UTC         = 2'b01;
  localparam logic [1:0] TSF_RT          = 2'b10;

  localparam int HDR_TYPE_LSB   = 28;
  localparam int HDR_C_BIT      = 27;
  localparam int HDR_TSI_LSB    = 22;
  localparam int HDR_TSF_LSB    = 20;
  localparam int HDR_CNT_LSB    = 16;
  localparam int BASE_HDR_WORDS = 5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_STRM_ID = 4'd2,
    ST_CLASS_0 = 4'd3,
    ST_CLASS_1 = 4'd4,
    ST_TSI     = 4'd5,
    ST_TSF_0   = 4'd6,
    ST_TSF_1   = 4'd7,
    ST_PAYLOAD = 4'd8,
    ST_DONE    = 4'd9,
    ST_ERROR   = 4'd10
  } v49_state_e;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } axis_beat_t;

  function automatic logic [31:0] v49_hdr(
    input logic        c,
    input logic [3:0]  cnt,
    input logic [15:0] size
  );
    v49_hdr = '0;
    v49_hdr[HDR_TYPE_LSB +: 4] = PKT_TYPE_IF_SID;
    v49_hdr[HDR_C_BIT]         = c;
    v49_hdr[HDR_TSI_LSB +: 2]  = TSI_UTC;
    v49_hdr[HDR_TSF_LSB +: 2]  = TSF_RT;
    v49_hdr[HDR_CNT_LSB +: 4]  = cnt;
    v49_hdr[15:0]              = size;
  endfunction

endpackage

// File: rtl/vita49_pack_if.sv
// AXI-Stream bundle for the VITA-49 datapath.
// Master drives data/valid/last, slave drives ready.
interface vita49_pack_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/vita49_pack_reg_slice.sv
// Single-stage AXI-Stream register carrying data+last.
// flush drops the held beat without a transfer.
module axis_reg_slice
  import vita49_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  axis_beat_t in_beat,
  output logic       in_ready,
  output logic       out_valid,
  output axis_beat_t out_beat,
  input  logic       out_ready
);

  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_beat <= in_beat;
    end
  end

endmodule

// File: rtl/vita49_pack.sv
// Transmit-side VITA-49 IF data framer.
// Wraps raw samples with header, stream ID, optional class ID and timestamps.
module vita49_pack
  import vita49_pkg::*;
#(
  parameter int          INCLUDE_CLASS_ID = 0,
  parameter logic [23:0] CLASS_OUI        = 24'h0,
  parameter logic [31:0] CLASS_INFO       = 32'h0
) (
  input  logic         AXIS_ACLK,
  input  logic         AXIS_ARESETN,
  vita49_pack_if.slave  s_axis,
  vita49_pack_if.master m_axis,
  input  logic [31:0]  ctrl,
  output logic [31:0]  status,
  input  logic [31:0]  streamID,
  input  logic [31:0]  words_to_pack,
  input  logic [15:0]  payload_words,
  input  logic [31:0]  timestamp_sec,
  input  logic [63:0]  timestamp_fsec
);

  localparam bit HAS_CID = (INCLUDE_CLASS_ID != 0);
  localparam logic [15:0] HDR_WORDS =
    16'(BASE_HDR_WORDS + (HAS_CID ? 2 : 0));

  logic start;
  logic reset_cmd;
  logic passthru;
  logic unused_ctrl;

  assign start       = ctrl[0];
  assign reset_cmd   = ctrl[1];
  assign passthru    = ctrl[2];
  assign unused_ctrl = ^ctrl[31:3];

  v49_state_e  state;
  logic        done;
  logic        tlast_err;
  logic        cfg_err;
  logic [3:0]  pkt_cnt;
  logic [31:0] word_cnt;
  logic [15:0] payload_cnt;
  logic [15:0] pkt_n;
  logic [31:0] tsi_q;
  logic [63:0] tsf_q;

  logic        load;
  logic        in_valid;
  axis_beat_t  in_beat;
  axis_beat_t  out_beat;

  logic [31:0] remain;
  logic [15:0] n_calc;
  logic [16:0] size_chk;
  logic        cfg_bad;
  logic        s_acc;
  logic        pkt_end;
  logic        run_end;

  assign remain   = words_to_pack - word_cnt;
  assign n_calc   = (remain < {16'h0, payload_words}) ?
                    remain[15:0] : payload_words;
  assign size_chk = {1'b0, HDR_WORDS} + {1'b0, payload_words};
  assign cfg_bad  = (payload_words == 16'h0) |
                    (words_to_pack == 32'h0) |
                    size_chk[16];

  assign s_axis.tready = ((state == ST_PAYLOAD) | passthru) & load;
  assign s_acc   = s_axis.tvalid & s_axis.tready;
  assign pkt_end = (payload_cnt + 16'd1) == pkt_n;
  assign run_end = (word_cnt + 32'd1) >= words_to_pack;

  assign status = {start, reset_cmd, passthru, AXIS_ARESETN,
                   16'h0, 9'h0, cfg_err, tlast_err, done};

  assign m_axis.tdata = out_beat.data;
  assign m_axis.tlast = out_beat.last;

  // Word offered to the output register this cycle.
  always_comb begin
    in_valid = 1'b0;
    in_beat  = '0;
    if (passthru) begin
      in_valid = s_axis.tvalid;
      in_beat  = {s_axis.tlast, s_axis.tdata};
    end else begin
      unique case (state)
        ST_HDR: begin
          in_valid     = 1'b1;
          in_beat.data = v49_hdr(HAS_CID, pkt_cnt,
                                 HDR_WORDS + n_calc);
        end
        ST_STRM_ID: begin
          in_valid     = 1'b1;
          in_beat.data = streamID;
        end
        ST_CLASS_0: begin
          in_valid     = 1'b1;
          in_beat.data = {8'h00, CLASS_OUI};
        end
        ST_CLASS_1: begin
          in_valid     = 1'b1;
          in_beat.data = CLASS_INFO;
        end
        ST_TSI: begin
          in_valid     = 1'b1;
          in_beat.data = tsi_q;
        end
        ST_TSF_0: begin
          in_valid     = 1'b1;
          in_beat.data = tsf_q[63:32];
        end
        ST_TSF_1: begin
          in_valid     = 1'b1;
          in_beat.data = tsf_q[31:0];
        end
        ST_PAYLOAD: begin
          in_valid = s_axis.tvalid;
          in_beat  = {pkt_end, s_axis.tdata};
        end
        default: ;
      endcase
    end
  end

  axis_reg_slice u_oreg (
    .clk       (AXIS_ACLK),
    .rst_n     (AXIS_ARESETN),
    .flush     (reset_cmd),
    .in_valid  (in_valid),
    .in_beat   (in_beat),
    .in_ready  (load),
    .out_valid (m_axis.tvalid),
    .out_beat  (out_beat),
    .out_ready (m_axis.tready)
  );

  // reset_cmd behaves as a second synchronous reset for the framer.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN || reset_cmd) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      tlast_err   <= 1'b0;
      cfg_err     <= 1'b0;
      pkt_cnt     <= 4'hF;
      word_cnt    <= 32'h0;
      payload_cnt <= 16'h0;
      pkt_n       <= 16'h0;
      tsi_q       <= 32'h0;
      tsf_q       <= 64'h0;
    end else if (!passthru) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
              state   <= ST_ERROR;
            end else begin
              state   <= ST_HDR;
              pkt_cnt <= pkt_cnt + 4'd1;
              tsi_q   <= timestamp_sec;
              tsf_q   <= timestamp_fsec;
            end
          end
        end
        ST_HDR: begin
          pkt_n <= n_calc;
          if (load) state <= ST_STRM_ID;
        end
        ST_STRM_ID:
          if (load) state <= HAS_CID ? ST_CLASS_0 : ST_TSI;
        ST_CLASS_0: if (load) state <= ST_CLASS_1;
        ST_CLASS_1: if (load) state <= ST_TSI;
        ST_TSI:     if (load) state <= ST_TSF_0;
        ST_TSF_0:   if (load) state <= ST_TSF_1;
        ST_TSF_1:   if (load) state <= ST_PAYLOAD;
        ST_PAYLOAD: begin
          if (s_acc) begin
            word_cnt <= word_cnt + 32'd1;
            if (s_axis.tlast && !pkt_end) tlast_err <= 1'b1;
            if (pkt_end) begin
              payload_cnt <= 16'h0;
              if (run_end) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state   <= ST_HDR;
                pkt_cnt <= pkt_cnt + 4'd1;
                tsi_q   <= timestamp_sec;
                tsf_q   <= timestamp_fsec;
              end
            end else begin
              payload_cnt <= payload_cnt + 16'd1;
            end
          end
        end
        ST_DONE:  ;
        ST_ERROR: ;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
